// File: rtl/vu_acchi.sv
// ---------------------------------------------------------------------------
// vu_acchi -- accumulator high-slice carry resolver
//
// Purpose:
//   Resolves the true carry into the upper W bits of the vector-unit MAC
//   accumulator, then applies the product high slice plus that carry to the
//   accumulator high register.
//
//   The true carry comes from three carry-outs:
//     - co_l    complemented carry-out of the 25-bit adjust field
//     - csa_co  carry-save adder carry-out
//     - cpa_co  carry-propagate adder carry-out
//
//   The datapath is a two-stage pipeline that stalls as a whole.
//   The accumulator has a synchronous clear and a sticky signed-overflow
//   flag.
//
// Ports:
//   clk        in   1  clock, rising edge
//   reset_l    in   1  asynchronous active-low reset
//   valid_in   in   1  stage-1 capture qualifier
//   co_l       in   1  complemented adjust-field carry-out (stage-1 timing)
//   csa_co     in   1  carry-save carry-out (stage-1 timing)
//   prod_hi    in   W  sign-extended product high slice (stage-1 timing)
//   op         in   1  0 = accumulate, 1 = load (stage-1 timing)
//   cpa_co     in   1  carry-propagate carry-out (stage-2 timing)
//   stall      in   1  freezes both stages
//   clear      in   1  synchronous clear of acc_hi and ovf
//   acc_hi     out  W  accumulator high slice
//   out_valid  out  1  pulse: acc_hi reflects a completed op
//   ovf        out  1  sticky signed overflow
// ---------------------------------------------------------------------------
module vu_acchi #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset_l,
   input  logic         valid_in,
   input  logic         co_l,
   input  logic         csa_co,
   input  logic [W-1:0] prod_hi,
   input  logic         op,
   input  logic         cpa_co,
   input  logic         stall,
   input  logic         clear,
   output logic [W-1:0] acc_hi,
   output logic         out_valid,
   output logic         ovf
);

   localparam logic OP_ACC  = 1'b0;
   localparam logic OP_LOAD = 1'b1;

   // Stage-1 registers.
   logic                vld_p1;
   logic                co_l_p1;
   logic                csa_co_p1;
   logic signed [W-1:0] prod_hi_p1;
   logic                op_p1;

   // Stage-2 combinational results.
   logic                tc;
   logic signed [W-1:0] acc_s;
   logic signed [W-1:0] opnd_sum;
   logic signed [W-1:0] acc_sum;
   logic signed [W-1:0] acc_next;
   logic                ovf_set;
   logic                s2_fire;

   // ------------------------------------------------------------------------
   // Helper functions
   // ------------------------------------------------------------------------

   // co_l arrives complemented.
   // XNOR with csa_co gives the half-resolved carry.
   // The carry-propagate carry-out then flips it to the true carry.
   function automatic logic true_carry(input logic co_l_v,
                                       input logic csa_v,
                                       input logic cpa_v);
      logic half;
      half = ~(co_l_v ^ csa_v);
      return half ^ cpa_v;
   endfunction

   // Modular add with carry-in.
   // The result wraps silently, so no bits are kept above W.
   function automatic logic signed [W-1:0] add_wrap(input logic signed [W-1:0] a,
                                                    input logic signed [W-1:0] b,
                                                    input logic            cin);
      logic [W-1:0] s;
      s = $unsigned(a) + $unsigned(b) + {{(W-1){1'b0}}, cin};
      return $signed(s);
   endfunction

   // Signed overflow flag for the accumulate result.
   // The addends are the accumulator and the product; the carry-in is part
   // of the sum.
   // It is the classic sign test: equal addend signs and a result sign that
   // differs from them.
   function automatic logic sat_ovf(input logic signed [W-1:0] a,
                                    input logic signed [W-1:0] b,
                                    input logic signed [W-1:0] r);
      return (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
   endfunction

   // ------------------------------------------------------------------------
   // Stage 1: capture operands and carries
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         vld_p1     <= 1'b0;
         co_l_p1    <= 1'b0;
         csa_co_p1  <= 1'b0;
         prod_hi_p1 <= '0;
         op_p1      <= OP_ACC;
      end else if (!stall) begin
         vld_p1 <= valid_in;
         if (valid_in) begin
            co_l_p1    <= co_l;
            csa_co_p1  <= csa_co;
            prod_hi_p1 <= $signed(prod_hi);
            op_p1      <= op;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Stage 2: resolve the true carry and update the accumulator
   // ------------------------------------------------------------------------
   assign acc_s   = $signed(acc_hi);
   assign s2_fire = vld_p1 & ~stall;

   always_comb begin
      tc       = true_carry(co_l_p1, csa_co_p1, cpa_co);
      opnd_sum = add_wrap(prod_hi_p1, '0, tc);
      acc_sum  = add_wrap(acc_s, prod_hi_p1, tc);
      acc_next = acc_s;
      ovf_set  = 1'b0;
      if (op_p1 == OP_LOAD) begin
         acc_next = opnd_sum;
      end else begin
         acc_next = acc_sum;
         ovf_set  = sat_ovf(acc_s, prod_hi_p1, acc_sum);
      end
   end

   // Clear beats an S2 update in the same cycle, and it acts even while
   // stall is high.
   // A load leaves the sticky flag alone.
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         acc_hi    <= '0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= s2_fire & ~clear;
         if (clear) begin
            acc_hi <= '0;
            ovf    <= 1'b0;
         end else if (s2_fire) begin
            acc_hi <= $unsigned(acc_next);
            if (ovf_set)
               ovf <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_vu_acchi.sv
module tb_vu_acchi;
   localparam int W = 16;

   logic         clk = 1'b0;
   logic         reset_l = 1'b0;
   logic         valid_in = 1'b0;
   logic         co_l = 1'b0;
   logic         csa_co = 1'b0;
   logic [W-1:0] prod_hi = '0;
   logic         op = 1'b0;
   logic         cpa_co = 1'b0;
   logic         stall = 1'b0;
   logic         clear = 1'b0;
   wire  [W-1:0] acc_hi;
   wire          out_valid;
   wire          ovf;

   int checks = 0;
   int errors = 0;
   int pulses = 0;

   // Reference model, transaction level.
   int m_acc = 0;
   bit m_ovf = 0;
   bit m_ov = 0;
   bit p_v = 0;
   bit p_co_l = 0;
   bit p_csa = 0;
   bit p_op = 0;
   int p_prod = 0;

   vu_acchi #(.W(W)) dut (
      .clk(clk), .reset_l(reset_l), .valid_in(valid_in), .co_l(co_l),
      .csa_co(csa_co), .prod_hi(prod_hi), .op(op), .cpa_co(cpa_co),
      .stall(stall), .clear(clear), .acc_hi(acc_hi), .out_valid(out_valid),
      .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int to_signed(input int v);
      return (v >= 32768) ? v - 65536 : v;
   endfunction

   task automatic model_reset();
      m_acc = 0; m_ovf = 0; m_ov = 0; p_v = 0;
   endtask

   // Predict the effect of the coming edge from the currently driven inputs.
   task automatic model_edge();
      int tc;
      int r;
      m_ov = p_v && !stall && !clear;
      if (clear) begin
         m_acc = 0;
         m_ovf = 0;
      end else if (p_v && !stall) begin
         tc = ((p_co_l == p_csa) ? 1 : 0) ^ (cpa_co ? 1 : 0);
         if (p_op) begin
            m_acc = (p_prod + tc) % 65536;
         end else begin
            r = to_signed(m_acc) + to_signed(p_prod) + tc;
            if (r > 32767 || r < -32768) m_ovf = 1;
            m_acc = (m_acc + p_prod + tc) % 65536;
         end
      end
      if (!stall) begin
         p_v = valid_in;
         if (valid_in) begin
            p_co_l = co_l; p_csa = csa_co; p_op = op; p_prod = int'(prod_hi);
         end
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) pulses++;
      check("acc_hi", {16'h0, acc_hi}, m_acc);
      check("out_valid", {31'h0, out_valid}, {31'h0, m_ov});
      check("ovf", {31'h0, ovf}, {31'h0, m_ovf});
   endtask

   // One complete op: present in S1, then supply cpa_co during S2.
   task automatic do_op(input bit o, input logic [W-1:0] p, input bit cl, input bit cs, input bit cp);
      valid_in = 1; op = o; prod_hi = p; co_l = cl; csa_co = cs;
      tick();
      valid_in = 0; cpa_co = cp;
      tick();
   endtask

   initial begin
      bit exp_tc [8] = '{1, 0, 0, 1, 0, 1, 1, 0};
      logic [2:0] cmb;
      int p0;

      // Reset state is visible without any clock edge.
      #3;
      check("rst_acc", {16'h0, acc_hi}, 32'h0);
      check("rst_ov", {31'h0, out_valid}, 32'h0);
      check("rst_ovf", {31'h0, ovf}, 32'h0);
      #9 reset_l = 1;
      model_reset();

      // Load with tc = 0.
      do_op(1, 16'h1234, 1, 0, 0);
      check("load_val", {16'h0, acc_hi}, 32'h1234);
      check("load_pulse", {31'h0, out_valid}, 32'h1);
      tick();
      check("load_single", {31'h0, out_valid}, 32'h0);

      // True-carry truth table, each case from 0x1234.
      for (int i = 0; i < 8; i++) begin
         cmb = i[2:0];
         do_op(1, 16'h1234, 1, 0, 0);
         do_op(0, 16'h0001, cmb[2], cmb[1], cmb[0]);
         check($sformatf("tc_%0d", i), {16'h0, acc_hi}, 32'h1235 + {31'h0, exp_tc[i]});
      end

      // Signed overflow, sticky across a load, and dropped by clear.
      do_op(1, 16'h7FFF, 1, 0, 0);
      do_op(0, 16'h0000, 0, 0, 0);
      check("ovf_acc", {16'h0, acc_hi}, 32'h8000);
      check("ovf_set", {31'h0, ovf}, 32'h1);
      do_op(1, 16'h0000, 1, 0, 0);
      check("ovf_sticky", {31'h0, ovf}, 32'h1);
      clear = 1;
      tick();
      clear = 0;
      check("ovf_clear", {31'h0, ovf}, 32'h0);

      // Back-to-back accumulates with a two-cycle stall.
      do_op(1, 16'h0000, 1, 0, 0);
      p0 = pulses;
      valid_in = 1; op = 0; prod_hi = 16'h0010; co_l = 1; csa_co = 0; cpa_co = 0;
      tick();
      tick();
      check("b2b_1", {16'h0, acc_hi}, 32'h0010);
      tick();
      check("b2b_2", {16'h0, acc_hi}, 32'h0020);
      valid_in = 0; stall = 1;
      tick();
      check("stall_ov", {31'h0, out_valid}, 32'h0);
      tick();
      check("stall_hold", {16'h0, acc_hi}, 32'h0020);
      stall = 0;
      tick();
      check("b2b_3", {16'h0, acc_hi}, 32'h0030);
      tick();
      check("b2b_pulses", pulses - p0, 32'd3);

      // Clear collides with an S2 accumulate; the following S1 op survives.
      do_op(1, 16'h0100, 1, 0, 0);
      valid_in = 1; op = 0; prod_hi = 16'h0005; co_l = 1; csa_co = 0;
      tick();
      clear = 1; prod_hi = 16'h0007; cpa_co = 0;
      tick();
      check("clr_acc", {16'h0, acc_hi}, 32'h0);
      check("clr_ov", {31'h0, out_valid}, 32'h0);
      clear = 0; valid_in = 0;
      tick();
      check("clr_next", {16'h0, acc_hi}, 32'h0007);
      check("clr_next_ov", {31'h0, out_valid}, 32'h1);

      // Asynchronous reset with an op in flight.
      do_op(1, 16'h1234, 1, 0, 0);
      valid_in = 1; op = 0; prod_hi = 16'h0001;
      tick();
      #1 reset_l = 0;
      #1;
      check("arst_acc", {16'h0, acc_hi}, 32'h0);
      check("arst_ovf", {31'h0, ovf}, 32'h0);
      check("arst_ov", {31'h0, out_valid}, 32'h0);
      model_reset();
      valid_in = 0;
      #2 reset_l = 1;
      tick();
      check("arst_nopulse", {31'h0, out_valid}, 32'h0);

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++) begin
         valid_in = ($urandom_range(0, 3) != 0);
         op       = ($urandom_range(0, 5) == 0);
         prod_hi  = W'($urandom);
         co_l     = 1'($urandom);
         csa_co   = 1'($urandom);
         if (!stall) cpa_co = 1'($urandom);
         stall    = ($urandom_range(0, 4) == 0);
         clear    = ($urandom_range(0, 24) == 0);
         tick();
      end
      valid_in = 0; stall = 0; clear = 0;
      tick();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
